// File: rtl/multicycle_ctrl_pkg.sv
// rtl/multicycle_ctrl_pkg.sv - states, datapath mux encodings, opcode/ALU codes for the multicycle sequencer
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC_R = 4'd2,
        S_WB_R   = 4'd3,
        S_ADDR   = 4'd4,
        S_MEM    = 4'd5,
        S_WB_MEM = 4'd6,
        S_BRANCH = 4'd7,
        S_JUMP   = 4'd8,
        S_TRAP   = 4'd9
    } stateT;

    typedef enum logic [2:0] {
        CLS_NONE, CLS_RTYPE, CLS_LOAD, CLS_STORE, CLS_BEQ, CLS_BNE, CLS_JUMP
    } instrClassT;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] WD_ALUOUT = 2'b00;
    localparam logic [1:0] WD_MDR    = 2'b01;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef struct packed {
        logic       memReq;
        logic       memWe;
        logic       memAddrSel;
        logic       irWrite;
        logic       pcWrite;
        logic [1:0] pcSrc;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [2:0] aluFunc;
        logic       rfWriteEnable;
        logic       rfWriteAddrSel;
        logic [1:0] rfWriteDataSel;
    } ctrlT;

endpackage

// File: rtl/mc_opdecode.sv
// rtl/mc_opdecode.sv - combinational opcode/function decode into instruction class and R-type ALU op
module mc_opdecode
    import multicycle_ctrl_pkg::*;
(
    input  logic [5:0] opc,
    input  logic [5:0] func,
    output instrClassT cls,
    output logic [2:0] aluFunc,
    output logic       valid
);

    always_comb begin
        cls     = CLS_NONE;
        aluFunc = ALU_ADD;
        case (opc)
            OP_RTYPE: begin
                case (func)
                    FN_ADD: begin cls = CLS_RTYPE; aluFunc = ALU_ADD; end
                    FN_SUB: begin cls = CLS_RTYPE; aluFunc = ALU_SUB; end
                    FN_AND: begin cls = CLS_RTYPE; aluFunc = ALU_AND; end
                    FN_OR:  begin cls = CLS_RTYPE; aluFunc = ALU_OR;  end
                    FN_SLT: begin cls = CLS_RTYPE; aluFunc = ALU_SLT; end
                    default: cls = CLS_NONE;
                endcase
            end
            OP_LW:   cls = CLS_LOAD;
            OP_SW:   cls = CLS_STORE;
            OP_BEQ:  cls = CLS_BEQ;
            OP_BNE:  cls = CLS_BNE;
            OP_J:    cls = CLS_JUMP;
            default: cls = CLS_NONE;
        endcase
    end

    assign valid = (cls != CLS_NONE);

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle MIPS32 sequencer: FSM, memory-wait timeout and sticky trap flags
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opc,
    input  logic [5:0] func,
    input  logic       aluZero,
    input  logic       memAck,
    output logic       memReq,
    output logic       memWe,
    output logic       memAddrSel,
    output logic       irWrite,
    output logic       pcWrite,
    output logic [1:0] pcSrc,
    output logic       aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [2:0] aluFunc,
    output logic       rfWriteEnable,
    output logic       rfWriteAddrSel,
    output logic [1:0] rfWriteDataSel,
    output logic       invOpcode,
    output logic       busErr,
    output logic [3:0] state
);

    localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] LAST_WAIT = CW'(MEM_TIMEOUT - 1);

    stateT          stateQ, stateNext;
    logic [5:0]     opcQ, funcQ;
    logic [CW-1:0]  waitCnt;
    logic           invQ, busQ, setInv, setBus, timeoutHit;
    logic [5:0]     decOpc, decFunc;
    instrClassT     decCls;
    logic [2:0]     decAluFunc;
    logic           decValid;
    ctrlT           ctrl, ctrlOut;

    // DECODE sees the live IR fields; every later state uses the latched copies.
    assign decOpc  = (stateQ == S_DECODE) ? opc  : opcQ;
    assign decFunc = (stateQ == S_DECODE) ? func : funcQ;

    mc_opdecode uDecode (
        .opc     (decOpc),
        .func    (decFunc),
        .cls     (decCls),
        .aluFunc (decAluFunc),
        .valid   (decValid)
    );

    assign timeoutHit = (MEM_TIMEOUT != 0) && !memAck && (waitCnt == LAST_WAIT);

    always_comb begin
        stateNext = stateQ;
        ctrl      = '0;
        setInv    = 1'b0;
        setBus    = 1'b0;
        case (stateQ)
            S_FETCH: begin
                ctrl.memReq  = 1'b1;
                ctrl.aluSrcB = SRCB_FOUR;
                ctrl.aluFunc = ALU_ADD;
                if (memAck) begin
                    ctrl.irWrite = 1'b1;
                    ctrl.pcWrite = 1'b1;
                    ctrl.pcSrc   = PC_SRC_ALU;
                    stateNext    = S_DECODE;
                end else if (timeoutHit) begin
                    setBus    = 1'b1;
                    stateNext = S_TRAP;
                end
            end
            S_DECODE: begin
                ctrl.aluSrcB = SRCB_IMM_SH2;
                ctrl.aluFunc = ALU_ADD;
                if (!decValid) begin
                    setInv    = 1'b1;
                    stateNext = S_TRAP;
                end else if (decCls == CLS_RTYPE)
                    stateNext = S_EXEC_R;
                else if (decCls == CLS_LOAD || decCls == CLS_STORE)
                    stateNext = S_ADDR;
                else if (decCls == CLS_BEQ || decCls == CLS_BNE)
                    stateNext = S_BRANCH;
                else
                    stateNext = S_JUMP;
            end
            S_EXEC_R: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluSrcB = SRCB_RT;
                ctrl.aluFunc = decAluFunc;
                stateNext    = S_WB_R;
            end
            S_WB_R: begin
                ctrl.rfWriteEnable  = 1'b1;
                ctrl.rfWriteAddrSel = 1'b1;
                ctrl.rfWriteDataSel = WD_ALUOUT;
                stateNext           = S_FETCH;
            end
            S_ADDR: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluSrcB = SRCB_IMM;
                ctrl.aluFunc = ALU_ADD;
                stateNext    = S_MEM;
            end
            S_MEM: begin
                ctrl.memReq     = 1'b1;
                ctrl.memAddrSel = 1'b1;
                ctrl.memWe      = (decCls == CLS_STORE);
                if (memAck)
                    stateNext = (decCls == CLS_STORE) ? S_FETCH : S_WB_MEM;
                else if (timeoutHit) begin
                    setBus    = 1'b1;
                    stateNext = S_TRAP;
                end
            end
            S_WB_MEM: begin
                ctrl.rfWriteEnable  = 1'b1;
                ctrl.rfWriteDataSel = WD_MDR;
                stateNext           = S_FETCH;
            end
            S_BRANCH: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluSrcB = SRCB_RT;
                ctrl.aluFunc = ALU_SUB;
                ctrl.pcSrc   = PC_SRC_ALUOUT;
                ctrl.pcWrite = ((decCls == CLS_BEQ) && aluZero) || ((decCls == CLS_BNE) && !aluZero);
                stateNext    = S_FETCH;
            end
            S_JUMP: begin
                ctrl.pcWrite = 1'b1;
                ctrl.pcSrc   = PC_SRC_JUMP;
                stateNext    = S_FETCH;
            end
            default: stateNext = S_TRAP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ  <= S_FETCH;
            opcQ    <= '0;
            funcQ   <= '0;
            waitCnt <= '0;
            invQ    <= 1'b0;
            busQ    <= 1'b0;
        end else begin
            stateQ <= stateNext;
            if (stateQ == S_DECODE) begin
                opcQ  <= opc;
                funcQ <= func;
            end
            // Counts only while still waiting in the same request state; any exit clears it.
            if ((stateQ == S_FETCH || stateQ == S_MEM) && !memAck && stateNext == stateQ)
                waitCnt <= waitCnt + CW'(1);
            else
                waitCnt <= '0;
            if (setInv) invQ <= 1'b1;
            if (setBus) busQ <= 1'b1;
        end
    end

    // Reset kills strobes combinationally so an in-flight memory request drops at once.
    assign ctrlOut        = rst_n ? ctrl : '0;
    assign memReq         = ctrlOut.memReq;
    assign memWe          = ctrlOut.memWe;
    assign memAddrSel     = ctrlOut.memAddrSel;
    assign irWrite        = ctrlOut.irWrite;
    assign pcWrite        = ctrlOut.pcWrite;
    assign pcSrc          = ctrlOut.pcSrc;
    assign aluSrcA        = ctrlOut.aluSrcA;
    assign aluSrcB        = ctrlOut.aluSrcB;
    assign aluFunc        = ctrlOut.aluFunc;
    assign rfWriteEnable  = ctrlOut.rfWriteEnable;
    assign rfWriteAddrSel = ctrlOut.rfWriteAddrSel;
    assign rfWriteDataSel = ctrlOut.rfWriteDataSel;
    assign invOpcode      = invQ;
    assign busErr         = busQ;
    assign state          = stateQ;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - table-driven bench for multicycle_ctrl plus timeout and async-reset sequences
module tb_multicycle_ctrl;

    localparam logic [3:0] SF = 4'd0, SD = 4'd1, SE = 4'd2, SWR = 4'd3, SA = 4'd4,
                           SM = 4'd5, SWM = 4'd6, SB = 4'd7, SJ = 4'd8, ST = 4'd9;
    localparam logic [2:0] A_AND = 3'b000, A_OR = 3'b001, A_ADD = 3'b010,
                           A_SUB = 3'b110, A_SLT = 3'b111;
    localparam logic [5:0] X6 = 6'h3F;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opc = 6'h0, func = 6'h0;
    logic       aluZero = 1'b0, memAck = 1'b0;
    logic       memReq, memWe, memAddrSel, irWrite, pcWrite, aluSrcA;
    logic [1:0] pcSrc, aluSrcB, rfWriteDataSel;
    logic [2:0] aluFunc;
    logic       rfWriteEnable, rfWriteAddrSel, invOpcode, busErr;
    logic [3:0] state;
    logic [16:0] outs;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multicycle_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .opc(opc), .func(func), .aluZero(aluZero), .memAck(memAck),
        .memReq(memReq), .memWe(memWe), .memAddrSel(memAddrSel), .irWrite(irWrite),
        .pcWrite(pcWrite), .pcSrc(pcSrc), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB),
        .aluFunc(aluFunc), .rfWriteEnable(rfWriteEnable), .rfWriteAddrSel(rfWriteAddrSel),
        .rfWriteDataSel(rfWriteDataSel), .invOpcode(invOpcode), .busErr(busErr), .state(state)
    );

    assign outs = {memReq, memWe, memAddrSel, irWrite, pcWrite, pcSrc, aluSrcA, aluSrcB,
                   aluFunc, rfWriteEnable, rfWriteAddrSel, rfWriteDataSel};

    function automatic logic [16:0] o(input logic rq, input logic we, input logic as,
                                      input logic ir, input logic pw, input logic [1:0] ps,
                                      input logic sa, input logic [1:0] sb, input logic [2:0] af,
                                      input logic rw, input logic ra, input logic [1:0] rd);
        return {rq, we, as, ir, pw, ps, sa, sb, af, rw, ra, rd};
    endfunction

    function automatic logic [16:0] fFetch(input logic ack);
        return o(1, 0, 0, ack, ack, 2'b00, 0, 2'b01, A_ADD, 0, 0, 2'b00);
    endfunction
    function automatic logic [16:0] fDecode();
        return o(0, 0, 0, 0, 0, 2'b00, 0, 2'b11, A_ADD, 0, 0, 2'b00);
    endfunction
    function automatic logic [16:0] fExec(input logic [2:0] af);
        return o(0, 0, 0, 0, 0, 2'b00, 1, 2'b00, af, 0, 0, 2'b00);
    endfunction
    function automatic logic [16:0] fWbR();
        return o(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 1, 1, 2'b00);
    endfunction
    function automatic logic [16:0] fAddr();
        return o(0, 0, 0, 0, 0, 2'b00, 1, 2'b10, A_ADD, 0, 0, 2'b00);
    endfunction
    function automatic logic [16:0] fMem(input logic we);
        return o(1, we, 1, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 0, 2'b00);
    endfunction
    function automatic logic [16:0] fWbMem();
        return o(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 1, 0, 2'b01);
    endfunction
    function automatic logic [16:0] fBranch(input logic pw);
        return o(0, 0, 0, 0, pw, 2'b01, 1, 2'b00, A_SUB, 0, 0, 2'b00);
    endfunction
    function automatic logic [16:0] fJump();
        return o(0, 0, 0, 0, 1, 2'b10, 0, 2'b00, 3'b000, 0, 0, 2'b00);
    endfunction

    typedef struct {
        logic        rst;
        logic [5:0]  opc;
        logic [5:0]  func;
        logic        zero;
        logic        ack;
        logic [3:0]  st;
        logic [16:0] out;
        logic        inv;
    } vecT;

    vecT vec[$];

    task automatic v(input logic r, input logic [5:0] op, input logic [5:0] fn, input logic z,
                     input logic a, input logic [3:0] st, input logic [16:0] out, input logic inv);
        vecT e;
        e.rst = r; e.opc = op; e.func = fn; e.zero = z; e.ack = a; e.st = st; e.out = out; e.inv = inv;
        vec.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic [5:0] op, input logic [5:0] fn, input logic z, input logic a);
        @(negedge clk);
        opc = op; func = fn; aluZero = z; memAck = a;
        #1;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0; memAck = 1'b0; opc = X6; func = X6;
        #1;
        chk("reset outs", 32'(outs), 32'h0);
        chk("reset state", 32'(state), 32'(SF));
        chk("reset flags", {30'b0, invOpcode, busErr}, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        // ADD, then SUB with one fetch wait, then AND/OR/SLT
        v(0, X6, X6, 0, 1, SF, fFetch(1), 0);
        v(0, 6'h00, 6'h20, 0, 0, SD, fDecode(), 0);
        v(0, X6, X6, 0, 0, SE, fExec(A_ADD), 0);
        v(0, X6, X6, 0, 0, SWR, fWbR(), 0);
        v(0, X6, X6, 0, 0, SF, fFetch(0), 0);
        v(0, X6, X6, 0, 1, SF, fFetch(1), 0);
        v(0, 6'h00, 6'h22, 0, 0, SD, fDecode(), 0);
        v(0, X6, X6, 0, 0, SE, fExec(A_SUB), 0);
        v(0, X6, X6, 0, 0, SWR, fWbR(), 0);
        v(0, X6, X6, 0, 1, SF, fFetch(1), 0);
        v(0, 6'h00, 6'h24, 0, 0, SD, fDecode(), 0);
        v(0, X6, X6, 0, 0, SE, fExec(A_AND), 0);
        v(0, X6, X6, 0, 0, SWR, fWbR(), 0);
        v(0, X6, X6, 0, 1, SF, fFetch(1), 0);
        v(0, 6'h00, 6'h25, 0, 0, SD, fDecode(), 0);
        v(0, X6, X6, 0, 0, SE, fExec(A_OR), 0);
        v(0, X6, X6, 0, 0, SWR, fWbR(), 0);
        v(0, X6, X6, 0, 1, SF, fFetch(1), 0);
        v(0, 6'h00, 6'h2A, 0, 0, SD, fDecode(), 0);
        v(0, X6, X6, 0, 0, SE, fExec(A_SLT), 0);
        v(0, X6, X6, 0, 0, SWR, fWbR(), 0);
        // LW with three MEM cycles: 7 cycles total
        v(0, X6, X6, 0, 1, SF, fFetch(1), 0);
        v(0, 6'h23, X6, 0, 0, SD, fDecode(), 0);
        v(0, X6, X6, 0, 0, SA, fAddr(), 0);
        v(0, X6, X6, 0, 0, SM, fMem(0), 0);
        v(0, X6, X6, 0, 0, SM, fMem(0), 0);
        v(0, X6, X6, 0, 1, SM, fMem(0), 0);
        v(0, X6, X6, 0, 0, SWM, fWbMem(), 0);
        // SW, with a stray ack in ADDR that must be ignored
        v(0, X6, X6, 0, 1, SF, fFetch(1), 0);
        v(0, 6'h2B, X6, 0, 0, SD, fDecode(), 0);
        v(0, X6, X6, 0, 1, SA, fAddr(), 0);
        v(0, X6, X6, 0, 1, SM, fMem(1), 0);
        // BEQ/BNE with both aluZero values
        v(0, X6, X6, 0, 1, SF, fFetch(1), 0);
        v(0, 6'h04, X6, 0, 0, SD, fDecode(), 0);
        v(0, X6, X6, 1, 0, SB, fBranch(1), 0);
        v(0, X6, X6, 0, 1, SF, fFetch(1), 0);
        v(0, 6'h05, X6, 0, 0, SD, fDecode(), 0);
        v(0, X6, X6, 1, 0, SB, fBranch(0), 0);
        v(0, X6, X6, 0, 1, SF, fFetch(1), 0);
        v(0, 6'h05, X6, 0, 0, SD, fDecode(), 0);
        v(0, X6, X6, 0, 0, SB, fBranch(1), 0);
        v(0, X6, X6, 0, 1, SF, fFetch(1), 0);
        v(0, 6'h04, X6, 0, 0, SD, fDecode(), 0);
        v(0, X6, X6, 0, 0, SB, fBranch(0), 0);
        // J whose fetch ack lands exactly on the timeout limit
        v(0, X6, X6, 0, 0, SF, fFetch(0), 0);
        v(0, X6, X6, 0, 0, SF, fFetch(0), 0);
        v(0, X6, X6, 0, 0, SF, fFetch(0), 0);
        v(0, X6, X6, 0, 1, SF, fFetch(1), 0);
        v(0, 6'h02, X6, 0, 0, SD, fDecode(), 0);
        v(0, X6, X6, 0, 0, SJ, fJump(), 0);
        // invalid opcode traps and stays put
        v(0, X6, X6, 0, 1, SF, fFetch(1), 0);
        v(0, 6'h3F, X6, 0, 0, SD, fDecode(), 0);
        v(0, X6, X6, 0, 0, ST, 17'h0, 1);
        v(0, X6, X6, 1, 1, ST, 17'h0, 1);
        v(0, X6, X6, 0, 0, ST, 17'h0, 1);
        // unsupported R-type function (JR) after reset
        v(1, X6, X6, 0, 1, SF, fFetch(1), 0);
        v(0, 6'h00, 6'h08, 0, 0, SD, fDecode(), 0);
        v(0, X6, X6, 0, 0, ST, 17'h0, 1);
        v(0, X6, X6, 0, 1, ST, 17'h0, 1);

        doReset();
        for (int i = 0; i < vec.size(); i++) begin
            if (vec[i].rst) doReset();
            cyc(vec[i].opc, vec[i].func, vec[i].zero, vec[i].ack);
            chk($sformatf("row%0d state", i), 32'(state), 32'(vec[i].st));
            chk($sformatf("row%0d outs", i), 32'(outs), 32'(vec[i].out));
            chk($sformatf("row%0d flags", i), {30'b0, invOpcode, busErr}, {30'b0, vec[i].inv, 1'b0});
        end

        // fetch timeout: four unanswered cycles, no IR load, then bus-error trap
        doReset();
        for (int k = 0; k < 4; k++) begin
            cyc(X6, X6, 0, 0);
            chk($sformatf("tmo fetch%0d state", k), 32'(state), 32'(SF));
            chk($sformatf("tmo fetch%0d irWrite", k), 32'(irWrite), 32'h0);
            chk($sformatf("tmo fetch%0d memReq", k), 32'(memReq), 32'h1);
        end
        for (int k = 0; k < 2; k++) begin
            cyc(X6, X6, 0, k[0]);
            chk($sformatf("tmo trap%0d state", k), 32'(state), 32'(ST));
            chk($sformatf("tmo trap%0d outs", k), 32'(outs), 32'h0);
            chk($sformatf("tmo trap%0d flags", k), {30'b0, invOpcode, busErr}, 32'h1);
        end

        // reset asserted mid-SW drops the memory strobes without waiting for a clock
        doReset();
        cyc(X6, X6, 0, 1);
        cyc(6'h2B, X6, 0, 0);
        cyc(X6, X6, 0, 0);
        cyc(X6, X6, 0, 0);
        chk("sw mem state", 32'(state), 32'(SM));
        chk("sw mem req/we", {30'b0, memReq, memWe}, 32'h3);
        #1 rst_n = 1'b0;
        #1;
        chk("async rst req/we", {30'b0, memReq, memWe}, 32'h0);
        chk("async rst state", 32'(state), 32'(SF));
        chk("async rst outs", 32'(outs), 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        cyc(X6, X6, 0, 0);
        chk("post rst state", 32'(state), 32'(SF));
        chk("post rst outs", 32'(outs), 32'(fFetch(0)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
